png_pixel_invert_stream: RTL

//  Hardware end of the PNG image flow: accepts a raster byte stream (row-major, channel-interleaved,
//  as produced from an image_info/pixels buffer), inverts each colour byte (255-x), and emits it

---
 rtl/png_stream_pkg.sv | 27 ++
 rtl/png_skid_buf.sv | 54 +++++
 rtl/png_pixel_invert_stream.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/png_stream_pkg.sv
// Shared types and constants for the PNG pixel invert stream.
package png_stream_pkg;

  localparam int DIM_W_DEF   = 16;
  localparam int CNT_W_DEF   = 32;
  localparam int MAX_CHANNEL = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_beat_t;

  // Bytes per pixel must be 1..MAX_CHANNEL.
  function automatic logic ch_ok(input logic [2:0] ch);
    return (ch != 3'd0) && (32'(ch) <= MAX_CHANNEL);
  endfunction

endpackage

// File: rtl/png_skid_buf.sv
// Two-entry valid/ready buffer of pix_beat_t with a registered input ready.
// `en` says whether the upstream side may be accepted in the next cycle.
module png_skid_buf
  import png_stream_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  input  logic      in_valid,
  output logic      in_ready,
  input  pix_beat_t in_beat,
  output logic      out_valid,
  input  logic      out_ready,
  output pix_beat_t out_beat
);

  pix_beat_t  mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] cnt, cnt_nxt;
  logic       push, pop;

  assign push      = in_valid && in_ready;
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_beat  = mem[rd_ptr];

  // Occupancy after this edge; ready is derived from it so it can be a flop.
  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop) cnt_nxt = cnt + 2'd1;
    else if (pop && !push) cnt_nxt = cnt - 2'd1;
  end

  // Storage, pointers and the registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt      <= cnt_nxt;
      in_ready <= en && (cnt_nxt != 2'd2);
    end
  end

endmodule

// File: rtl/png_pixel_invert_stream.sv
// PNG raster byte stream inverter: 255-x per byte, with sof/eol/eof markers.
// Optional macro PNG_ALPHA_KEEP_EN: alpha bytes (ch==4 dpt 3, ch==2 dpt 1)
// pass through unchanged.
module png_pixel_invert_stream
  import png_stream_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic [2:0]       cfg_channel,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof
);

  state_t           state, state_nxt;
  logic [DIM_W-1:0] w_q, h_q, pxl, line;
  logic [2:0]       ch_q, dpt;
  logic [CNT_W-1:0] total_q, byte_cnt;
  logic             bad, acc, last, eof_hs, keep;
  logic             last_dpt, last_pxl, last_line;
  pix_beat_t        in_beat, out_beat;

  assign bad    = (w_q == '0) || (h_q == '0) || !ch_ok(ch_q);
  assign acc    = s_valid && s_ready;
  assign last   = (byte_cnt == total_q - CNT_W'(1));
  assign eof_hs = m_valid && m_ready && m_eof;
  assign busy   = (state != IDLE);

  assign last_dpt  = (dpt == ch_q - 3'd1);
  assign last_pxl  = (pxl == w_q - DIM_W'(1));
  assign last_line = (line == h_q - DIM_W'(1));

`ifdef PNG_ALPHA_KEEP_EN
  assign keep = ((ch_q == 3'd4) && (dpt == 3'd3)) || ((ch_q == 3'd2) && (dpt == 3'd1));
`else
  assign keep = 1'b0;
`endif

  // Beat formed from the position counters at accept time.
  always_comb begin
    in_beat      = '0;
    in_beat.data = keep ? s_data : ~s_data;
    in_beat.sof  = (dpt == 3'd0) && (pxl == '0) && (line == '0);
    in_beat.eol  = last_dpt && last_pxl;
    in_beat.eof  = last_dpt && last_pxl && last_line;
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = CHECK;
      CHECK: state_nxt = bad ? IDLE : RUN;
      RUN:   if (acc && last) state_nxt = DRAIN;
      DRAIN: if (eof_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, config latch, status and position counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      w_q      <= '0;
      h_q      <= '0;
      ch_q     <= '0;
      total_q  <= '0;
      byte_cnt <= '0;
      dpt      <= '0;
      pxl      <= '0;
      line     <= '0;
    end else begin
      state <= state_nxt;
      done  <= ((state == CHECK) && bad) || ((state == DRAIN) && eof_hs);
      case (state)
        IDLE: if (start) begin
          w_q  <= cfg_width;
          h_q  <= cfg_height;
          ch_q <= cfg_channel;
          err  <= 1'b0;
        end
        CHECK: begin
          err      <= bad;
          total_q  <= CNT_W'(w_q) * CNT_W'(h_q) * CNT_W'(ch_q);
          byte_cnt <= '0;
          dpt      <= '0;
          pxl      <= '0;
          line     <= '0;
        end
        RUN: if (acc) begin
          byte_cnt <= byte_cnt + CNT_W'(1);
          if (!last_dpt) dpt <= dpt + 3'd1;
          else begin
            dpt <= '0;
            if (!last_pxl) pxl <= pxl + DIM_W'(1);
            else begin
              pxl  <= '0;
              line <= last_line ? '0 : line + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  png_skid_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .en        (state_nxt == RUN),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_beat   (in_beat),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_beat  (out_beat)
  );

  // Markers are only meaningful alongside a valid byte.
  assign m_data = out_beat.data;
  assign m_sof  = m_valid && out_beat.sof;
  assign m_eol  = m_valid && out_beat.eol;
  assign m_eof  = m_valid && out_beat.eof;

endmodule
